// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the icache and IF/ID: owns the fetch PC, buffers {instr, PC+4}.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int                DEPTH   = 4,
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = {WORD_W{1'b0}}
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     ihit,
    input  logic [WORD_W-1:0]        imemload,
    output logic                     imemREN,
    output logic [WORD_W-1:0]        imemaddr,
    input  logic                     redirect,
    input  logic [WORD_W-1:0]        redirect_pc,
    input  logic                     halt_fetch,
    input  logic                     deq,
    output logic                     valid,
    output logic [WORD_W-1:0]        instr,
    output logic [WORD_W-1:0]        npc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WORD_W-1:0] PC_STEP  = {{(WORD_W-3){1'b0}}, 3'b100};

    logic [WORD_W-1:0] mem_instr_r [DEPTH];
    logic [WORD_W-1:0] mem_npc_r   [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [WORD_W-1:0] fetch_pc_r;
    logic              halted_r;

    logic              full_s;
    logic              empty_s;
    logic              ren_s;
    logic              fetch_s;
    logic              bypass_s;
    logic              consume_s;
    logic              enq_s;
    logic              pop_s;
    logic [WORD_W-1:0] pc_plus4_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [WORD_W-1:0] fetch_pc_nxt_s;

    assign full_s     = (count_r == CNT_FULL);
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign ren_s      = !full_s && !halted_r && !redirect;
    assign fetch_s    = ren_s && ihit;
    assign pc_plus4_s = fetch_pc_r + PC_STEP;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_s = empty_s && fetch_s;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed word taken by decode in the same cycle never touches storage.
    assign consume_s = bypass_s && deq;
    assign enq_s     = fetch_s && !consume_s;
    assign pop_s     = deq && !empty_s && !redirect;

    assign imemREN  = ren_s;
    assign imemaddr = fetch_pc_r;
    assign count    = count_r;

    // Head-of-queue presentation, with the bypassed word shown when the queue is empty.
    always_comb begin
        valid = 1'b0;
        instr = {WORD_W{1'b0}};
        npc   = {WORD_W{1'b0}};
        if (!empty_s) begin
            valid = 1'b1;
            instr = mem_instr_r[head_r];
            npc   = mem_npc_r[head_r];
        end else if (bypass_s) begin
            valid = 1'b1;
            instr = imemload;
            npc   = pc_plus4_s;
        end else begin
            valid = 1'b0;
        end
    end

    // Occupancy and fetch PC next-state.
    always_comb begin
        count_nxt_s    = count_r;
        fetch_pc_nxt_s = fetch_pc_r;
        case ({enq_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (redirect) begin
            fetch_pc_nxt_s = {redirect_pc[WORD_W-1:2], 2'b00};
        end else if (fetch_s) begin
            fetch_pc_nxt_s = pc_plus4_s;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
    end

    // Control state: pointers, occupancy, fetch PC and the sticky halt flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            fetch_pc_r <= PC_INIT;
            halted_r   <= 1'b0;
        end else begin
            halted_r   <= halted_r || halt_fetch;
            fetch_pc_r <= fetch_pc_nxt_s;
            if (redirect) begin
                head_r  <= {PTR_W{1'b0}};
                tail_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_nxt_s;
                if (enq_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
            end
        end
    end

    // Entry storage, cleared on reset so stale words never reach decode.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_r[i] <= {WORD_W{1'b0}};
                mem_npc_r[i]   <= {WORD_W{1'b0}};
            end
        end else if (enq_s) begin
            mem_instr_r[tail_r] <= imemload;
            mem_npc_r[tail_r]   <= pc_plus4_s;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam logic [W-1:0] PC_INIT = 32'h0000_0000;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         ihit;
    logic [W-1:0] imemload;
    logic         imemREN;
    logic [W-1:0] imemaddr;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         halt_fetch;
    logic         deq;
    logic         valid;
    logic [W-1:0] instr;
    logic [W-1:0] npc;
    logic [2:0]   count;

    fetch_queue #(.DEPTH(DEPTH), .WORD_W(W), .PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_fetch(halt_fetch), .deq(deq),
        .valid(valid), .instr(instr), .npc(npc), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] ins;
        logic [W-1:0] pc4;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] m_pc;
    logic         m_halted;
    int           total = 0;
    int           bad   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_ren();
        return (mq.size() < DEPTH) && !m_halted && !redirect;
    endfunction

    function automatic logic m_bypass();
`ifdef FETCHQ_BYPASS_EN
        return (mq.size() == 0) && m_ren() && ihit;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = PC_INIT;
        m_halted = 1'b0;
    endtask

    // Compare every DUT output with what the model says for the current inputs.
    task automatic check_outputs();
        logic         e_valid;
        logic [W-1:0] e_instr, e_npc;
        e_valid = (mq.size() != 0) || m_bypass();
        e_instr = '0;
        e_npc   = '0;
        if (mq.size() != 0) begin
            e_instr = mq[0].ins;
            e_npc   = mq[0].pc4;
        end else if (m_bypass()) begin
            e_instr = imemload;
            e_npc   = m_pc + 32'd4;
        end
        check_eq("imemREN",  {31'd0, imemREN}, {31'd0, m_ren()});
        check_eq("imemaddr", imemaddr, m_pc);
        check_eq("valid",    {31'd0, valid}, {31'd0, e_valid});
        check_eq("instr",    instr, e_instr);
        check_eq("npc",      npc, e_npc);
        check_eq("count",    {29'd0, count}, mq.size());
    endtask

    // Apply one clock edge's worth of specified behaviour to the model.
    task automatic model_edge();
        logic take, pop;
        take = m_ren() && ihit;
        pop  = deq && ((mq.size() != 0) || m_bypass()) && !redirect;
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[W-1:2], 2'b00};
        end else if (m_bypass() && deq) begin
            m_pc = m_pc + 32'd4;
        end else begin
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (take) begin
                mq.push_back('{ins: imemload, pc4: m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        m_halted = m_halted || halt_fetch;
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic drive(input logic h, input logic d, input logic r, input logic hf);
        ihit = h; deq = d; redirect = r; halt_fetch = hf;
        imemload = 32'h2000_0000 + (imemaddr >> 2);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; redirect = 1'b0;
        redirect_pc = '0; halt_fetch = 1'b0; deq = 1'b0;
        model_reset();
        #2 check_outputs();
        @(negedge CLK);
        nRST = 1'b1;

        // Fill from reset.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check_eq("fill_count", {29'd0, count}, 32'd4);
        check_eq("fill_ren",   {31'd0, imemREN}, 32'd0);
        check_eq("fill_instr", instr, 32'h2000_0000);
        check_eq("fill_npc",   npc, 32'd4);
        cycle();

        // Pop one from full: no enqueue that cycle, fetch resumes at 16.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check_eq("pop_full_count", {29'd0, count}, 32'd3);
        check_eq("resume_addr", imemaddr, 32'd16);
        check_eq("resume_ren",  {31'd0, imemREN}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            cycle();
        end

        // Steady state at count 2.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check_eq("steady_count", {29'd0, count}, 32'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();

        // Redirect with count 3 beats a concurrent ihit and deq.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        redirect_pc = 32'h0000_0103;
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("redir_count", {29'd0, count}, 32'd0);
        check_eq("redir_valid", {31'd0, valid}, 32'd0);
        check_eq("redir_addr",  imemaddr, 32'h0000_0100);
        check_eq("redir_ren",   {31'd0, imemREN}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end

        // Halt, drain, and confirm redirect does not restart fetch.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check_eq("halt_drained", {29'd0, count}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        redirect_pc = 32'h0000_0040;
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check_eq("halt_sticky_ren", {31'd0, imemREN}, 32'd0);

`ifdef FETCHQ_BYPASS_EN
        nRST = 1'b0; #1 model_reset();
        @(negedge CLK); nRST = 1'b1;
        ihit = 1'b1; deq = 1'b1; redirect = 1'b0; halt_fetch = 1'b0;
        imemload = 32'h8C22_0004;
        #1;
        check_eq("byp_valid", {31'd0, valid}, 32'd1);
        check_eq("byp_instr", instr, 32'h8C22_0004);
        check_eq("byp_npc",   npc, PC_INIT + 32'd4);
        cycle();
        check_eq("byp_count", {29'd0, count}, 32'd0);
`endif

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #3 nRST = 1'b0;
        #1 model_reset();
        check_eq("arst_count", {29'd0, count}, 32'd0);
        check_eq("arst_addr",  imemaddr, PC_INIT);
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic with occasional redirects, halts and resets.
        for (int n = 0; n < 3000; n++) begin
            ihit        = ($urandom_range(0, 99) < 70);
            deq         = ($urandom_range(0, 99) < 55);
            redirect    = ($urandom_range(0, 99) < 4);
            halt_fetch  = ($urandom_range(0, 999) < 3);
            redirect_pc = $urandom;
            imemload    = $urandom;
            if (n % 400 == 399) begin
                nRST = 1'b0;
                #1 model_reset();
                check_outputs();
                @(negedge CLK);
                nRST = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
